// File: rtl/t6507lp_alu_seq_pkg.sv
// t6507lp_alu_seq_pkg
// Shared definitions for the T6507LP ALU sequencer:
//   - immediate-mode opcode constants understood by the ALU
//   - bit positions of the flags in the ALU status byte
//   - sequencer state encodings
package t6507lp_alu_seq_pkg;

    localparam logic [7:0] ORA_IMM = 8'h09;
    localparam logic [7:0] AND_IMM = 8'h29;
    localparam logic [7:0] EOR_IMM = 8'h49;
    localparam logic [7:0] ADC_IMM = 8'h69;
    localparam logic [7:0] LDA_IMM = 8'hA9;
    localparam logic [7:0] CMP_IMM = 8'hC9;
    localparam logic [7:0] SBC_IMM = 8'hE9;

    localparam int C = 0;
    localparam int Z = 1;
    localparam int I = 2;
    localparam int D = 3;
    localparam int B = 4;
    localparam int V = 6;
    localparam int N = 7;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        ISSUE    = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/t6507lp_rr_arb2.sv
// t6507lp_rr_arb2
// Two-way round-robin grant. A sole requester always wins; on a tie the port
// that was not granted last wins. The last-grant pointer advances only when
// the grant is actually consumed (advance high).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; pointer resets to "port 1 last"
//   req      in   [1:0] request per port
//   advance  in   grant consumed this cycle
//   grant    out  [1:0] one-hot (or zero) grant, combinational from req
module t6507lp_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;  // 1 = port 1 was granted last

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/t6507lp_alu_seq.sv
// t6507lp_alu_seq
// Shares the single T6507LP ALU between the execution unit (port 0) and an
// optional debug requester (port 1). One command at a time: handshake, one
// ISSUE cycle with alu_enable_o, ALU_LATENCY WAIT cycles, one RESP cycle that
// strobes the owner's rsp valid. Also sequences the ALU's active-low reset.
// Optional feature macro: T6507LP_ALU_SEQ_DBG_PORT_EN (adds port 1 + arbiter).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_valid_i/reqN_ready_o    command handshake per port
//   reqN_opcode_i, reqN_a_i      command opcode and operand per port
//   rspN_valid_o                 one-cycle response strobe per port
//   rsp_result_o, rsp_status_o   shared captured result/status
//   alu_n_rst_o, alu_enable_o    ALU reset (active-low) and enable pulse
//   alu_opcode_o, alu_a_o        command presented to the ALU
//   alu_result_i, alu_status_i   ALU outputs
module t6507lp_alu_seq
    import t6507lp_alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY     = 1,
    parameter int RST_HOLD_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [7:0] req0_opcode_i,
    input  logic [7:0] req0_a_i,
`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [7:0] req1_opcode_i,
    input  logic [7:0] req1_a_i,
    output logic       rsp1_valid_o,
`endif
    output logic       rsp0_valid_o,
    output logic [7:0] rsp_result_o,
    output logic [7:0] rsp_status_o,
    output logic       alu_n_rst_o,
    output logic       alu_enable_o,
    output logic [7:0] alu_opcode_o,
    output logic [7:0] alu_a_o,
    input  logic [7:0] alu_result_i,
    input  logic [7:0] alu_status_i
);

    localparam logic [1:0] WAIT_INIT = 2'(ALU_LATENCY - 1);
    localparam logic [2:0] HOLD_INIT = 3'(RST_HOLD_CYCLES - 1);

    seq_state_t state, state_nxt;
    logic [2:0] hold_cnt;
    logic [1:0] wait_cnt;
    logic       idle;
    logic       handshake;
    logic       owner;
    logic [7:0] sel_opcode;
    logic [7:0] sel_a;

    assign idle = (state == IDLE);

`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
    logic [1:0] grant;

    t6507lp_rr_arb2 u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     ({req1_valid_i, req0_valid_i}),
        .advance (handshake),
        .grant   (grant)
    );

    assign req0_ready_o = idle & grant[0];
    assign req1_ready_o = idle & grant[1];
    assign handshake    = (req0_ready_o & req0_valid_i) | (req1_ready_o & req1_valid_i);
    assign sel_opcode   = grant[1] ? req1_opcode_i : req0_opcode_i;
    assign sel_a        = grant[1] ? req1_a_i      : req0_a_i;
    assign rsp1_valid_o = (state == RESP) & owner;

    // Owner id: which port the in-flight command belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner <= 1'b0;
        end else if (handshake) begin
            owner <= grant[1];
        end
    end
`else
    assign req0_ready_o = idle;
    assign handshake    = idle & req0_valid_i;
    assign sel_opcode   = req0_opcode_i;
    assign sel_a        = req0_a_i;
    assign owner        = 1'b0;
`endif

    assign rsp0_valid_o = (state == RESP) & ~owner;
    assign alu_enable_o = (state == ISSUE);
    assign alu_n_rst_o  = (state != RST_HOLD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RST_HOLD;
            hold_cnt     <= HOLD_INIT;
            wait_cnt     <= 2'd0;
            alu_opcode_o <= 8'h00;
            alu_a_o      <= 8'h00;
            rsp_result_o <= 8'h00;
            rsp_status_o <= 8'h00;
        end else begin
            state <= state_nxt;
            if ((state == RST_HOLD) && (hold_cnt != 3'd0)) begin
                hold_cnt <= hold_cnt - 3'd1;
            end
            // Latched command drives the ALU directly and holds until the next one.
            if (handshake) begin
                alu_opcode_o <= sel_opcode;
                alu_a_o      <= sel_a;
            end
            if (state == ISSUE) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if ((state == WAIT) && (wait_cnt == 2'd0)) begin
                rsp_result_o <= alu_result_i;
                rsp_status_o <= alu_status_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST_HOLD: if (hold_cnt == 3'd0) state_nxt = IDLE;
            IDLE:     if (handshake) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT;
            WAIT:     if (wait_cnt == 2'd0) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = RST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_t6507lp_alu_seq.sv
// tb_t6507lp_alu_seq
// Bench for t6507lp_alu_seq: DUT "a" with ALU_LATENCY=1, DUT "b" with
// ALU_LATENCY=3, each driving a small behavioural ALU. Works with and without
// T6507LP_ALU_SEQ_DBG_PORT_EN.
module tb_t6507lp_alu_seq;
    import t6507lp_alu_seq_pkg::*;

`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif
    localparam int LAT_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT a signals
    logic       a_req0_valid, a_req0_ready, a_rsp0_valid;
    logic [7:0] a_req0_opcode, a_req0_a;
    logic       a_req1_valid, a_req1_ready, a_rsp1_valid;
    logic [7:0] a_req1_opcode, a_req1_a;
    logic [7:0] a_rsp_result, a_rsp_status, a_alu_op, a_alu_a, a_alu_res, a_alu_st;
    logic       a_n_rst, a_en;

    // DUT b signals
    logic       b_req0_valid, b_req0_ready, b_rsp0_valid;
    logic [7:0] b_req0_opcode, b_req0_a;
    logic [7:0] b_rsp_result, b_rsp_status, b_alu_op, b_alu_a, b_alu_res, b_alu_st;
    logic       b_n_rst, b_en;

    t6507lp_alu_seq #(.ALU_LATENCY(1), .RST_HOLD_CYCLES(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(a_req0_valid), .req0_ready_o(a_req0_ready),
        .req0_opcode_i(a_req0_opcode), .req0_a_i(a_req0_a),
`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
        .req1_valid_i(a_req1_valid), .req1_ready_o(a_req1_ready),
        .req1_opcode_i(a_req1_opcode), .req1_a_i(a_req1_a),
        .rsp1_valid_o(a_rsp1_valid),
`endif
        .rsp0_valid_o(a_rsp0_valid),
        .rsp_result_o(a_rsp_result), .rsp_status_o(a_rsp_status),
        .alu_n_rst_o(a_n_rst), .alu_enable_o(a_en),
        .alu_opcode_o(a_alu_op), .alu_a_o(a_alu_a),
        .alu_result_i(a_alu_res), .alu_status_i(a_alu_st)
    );

`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
    logic       b_req1_ready, b_rsp1_valid;
    logic       b_req1_valid = 1'b0;
    logic [7:0] b_req1_opcode = 8'h00;
    logic [7:0] b_req1_a = 8'h00;
`else
    assign a_req1_ready = 1'b0;
    assign a_rsp1_valid = 1'b0;
`endif

    t6507lp_alu_seq #(.ALU_LATENCY(3), .RST_HOLD_CYCLES(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(b_req0_valid), .req0_ready_o(b_req0_ready),
        .req0_opcode_i(b_req0_opcode), .req0_a_i(b_req0_a),
`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
        .req1_valid_i(b_req1_valid), .req1_ready_o(b_req1_ready),
        .req1_opcode_i(b_req1_opcode), .req1_a_i(b_req1_a),
        .rsp1_valid_o(b_rsp1_valid),
`endif
        .rsp0_valid_o(b_rsp0_valid),
        .rsp_result_o(b_rsp_result), .rsp_status_o(b_rsp_status),
        .alu_n_rst_o(b_n_rst), .alu_enable_o(b_en),
        .alu_opcode_o(b_alu_op), .alu_a_o(b_alu_a),
        .alu_result_i(b_alu_res), .alu_status_i(b_alu_st)
    );

    // Behavioural ALU: accumulator, carry and overflow; returns {c, v, result}.
    function automatic logic [9:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] acc, input logic c, input logic v);
        logic [8:0] sum;
        logic [7:0] r;
        logic       nc, nv;
        r = acc; nc = c; nv = v;
        if (op == LDA_IMM) begin
            r = a;
        end else if (op == ADC_IMM) begin
            sum = {1'b0, acc} + {1'b0, a} + {8'b0, c};
            r   = sum[7:0];
            nc  = sum[8];
            nv  = (acc[7] == a[7]) && (r[7] != acc[7]);
        end
        return {nc, nv, r};
    endfunction

    function automatic logic [7:0] st_of(input logic [9:0] x);
        return {x[7], x[8], 4'b0000, (x[7:0] == 8'h00), x[9]};
    endfunction

    logic [7:0] ma_acc, mb_acc;
    logic       ma_c, ma_v, mb_c, mb_v;
    logic [9:0] ma_nx, mb_nx;
    logic [7:0] mb_r0, mb_r1, mb_s0, mb_s1;

    always_comb ma_nx = alu_f(a_alu_op, a_alu_a, ma_acc, ma_c, ma_v);
    always_comb mb_nx = alu_f(b_alu_op, b_alu_a, mb_acc, mb_c, mb_v);

    always @(posedge clk) begin
        if (!a_n_rst) begin
            ma_acc <= 8'h00; ma_c <= 1'b0; ma_v <= 1'b0;
        end else if (a_en) begin
            ma_acc <= ma_nx[7:0]; ma_c <= ma_nx[9]; ma_v <= ma_nx[8];
            a_alu_res <= ma_nx[7:0];
            a_alu_st  <= st_of(ma_nx);
        end
    end

    always @(posedge clk) begin
        if (!b_n_rst) begin
            mb_acc <= 8'h00; mb_c <= 1'b0; mb_v <= 1'b0;
        end else if (b_en) begin
            mb_acc <= mb_nx[7:0]; mb_c <= mb_nx[9]; mb_v <= mb_nx[8];
            mb_r0 <= mb_nx[7:0];
            mb_s0 <= st_of(mb_nx);
        end
        mb_r1 <= mb_r0; mb_s1 <= mb_s0;
        b_alu_res <= mb_r1; b_alu_st <= mb_s1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef T6507LP_ALU_SEQ_DBG_PORT_EN
    always @(negedge clk) begin
        checks++;
        if (a_req0_ready && a_req1_ready) begin
            errors++;
            $display("FAIL ready_exclusive: got both readys high at %0t, expected at most one", $time);
        end
    end
`endif

    // Issue one port-0 command on DUT a and check the full transaction timing.
    // Called at a sample point (posedge+4).
    task automatic cmd0(input logic [7:0] op, input logic [7:0] opa,
                        input logic [7:0] exp_r, input logic [7:0] exp_s);
        int n;
        a_req0_valid = 1'b1; a_req0_opcode = op; a_req0_a = opa;
        #1;
        n = 0;
        while (!a_req0_ready && n < 30) begin
            @(posedge clk); #4; n++;
        end
        if (n == 30) begin
            chk("cmd0_ready_timeout", 32'(n), 32'd0);
            a_req0_valid = 1'b0;
            return;
        end
        chk("cmd0_n_rst_high", 32'(a_n_rst), 32'd1);
        @(posedge clk); #1 a_req0_valid = 1'b0; #3;
        chk("cmd0_enable_T1", 32'(a_en), 32'd1);
        chk("cmd0_rsp_T1", 32'(a_rsp0_valid), 32'd0);
        repeat (LAT_A) begin
            @(posedge clk); #4;
            chk("cmd0_enable_wait", 32'(a_en), 32'd0);
            chk("cmd0_rsp_wait", 32'(a_rsp0_valid), 32'd0);
        end
        @(posedge clk); #4;
        chk("cmd0_rsp_valid", 32'(a_rsp0_valid), 32'd1);
        chk("cmd0_rsp1_quiet", 32'(a_rsp1_valid), 32'd0);
        chk("cmd0_result", 32'(a_rsp_result), 32'(exp_r));
        chk("cmd0_status", 32'(a_rsp_status), 32'(exp_s));
        @(posedge clk); #4;
        chk("cmd0_rsp_drop", 32'(a_rsp0_valid), 32'd0);
        chk("cmd0_result_hold", 32'(a_rsp_result), 32'(exp_r));
    endtask

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] exp_r;
        logic [7:0] exp_s;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        logic g;
        // {opcode, operand, result, status}; status = {N,V,0,0,0,0,Z,C}
        vecs[0] = '{LDA_IMM, 8'h05, 8'h05, 8'h00};
        vecs[1] = '{LDA_IMM, 8'hFF, 8'hFF, 8'h80};
        vecs[2] = '{ADC_IMM, 8'h01, 8'h00, 8'h03};
        vecs[3] = '{LDA_IMM, 8'h80, 8'h80, 8'h81};
        vecs[4] = '{ADC_IMM, 8'h7F, 8'h00, 8'h03};
        vecs[5] = '{LDA_IMM, 8'h40, 8'h40, 8'h01};
        vecs[6] = '{ADC_IMM, 8'h3F, 8'h80, 8'hC0};

        a_req0_valid = 1'b1; a_req0_opcode = LDA_IMM; a_req0_a = 8'h05;
        a_req1_valid = 1'b0; a_req1_opcode = 8'h00;   a_req1_a = 8'h00;
        b_req0_valid = 1'b0; b_req0_opcode = 8'h00;   b_req0_a = 8'h00;
        rst = 1'b1;

        // Reset held for three rising edges.
        @(posedge clk); #4;
        chk("rst_ready0", 32'(a_req0_ready), 32'd0);
        chk("rst_ready1", 32'(a_req1_ready), 32'd0);
        chk("rst_rsp0", 32'(a_rsp0_valid), 32'd0);
        chk("rst_rsp1", 32'(a_rsp1_valid), 32'd0);
        chk("rst_enable", 32'(a_en), 32'd0);
        chk("rst_n_rst", 32'(a_n_rst), 32'd0);
        chk("rst_result", 32'(a_rsp_result), 32'h00);
        chk("rst_status", 32'(a_rsp_status), 32'h00);
        chk("rst_alu_op", 32'(a_alu_op), 32'h00);
        chk("rst_alu_a", 32'(a_alu_a), 32'h00);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0; #3;
        chk("hold_R_n_rst", 32'(a_n_rst), 32'd0);
        chk("hold_R_ready", 32'(a_req0_ready), 32'd0);
        @(posedge clk); #4;
        chk("hold_R1_n_rst", 32'(a_n_rst), 32'd0);
        chk("hold_R1_ready", 32'(a_req0_ready), 32'd0);
        // The first table vector must handshake at R+2 (n_rst checked there).

        for (int i = 0; i < 7; i++) begin
            cmd0(vecs[i].op, vecs[i].a, vecs[i].exp_r, vecs[i].exp_s);
        end

        // Latency 3 on DUT b.
        b_req0_valid = 1'b1; b_req0_opcode = LDA_IMM; b_req0_a = 8'h37;
        #1;
        n = 0;
        while (!b_req0_ready && n < 30) begin
            @(posedge clk); #4; n++;
        end
        chk("lat3_ready_wait", 32'(n < 30), 32'd1);
        @(posedge clk); #1 b_req0_valid = 1'b0; #3;
        chk("lat3_enable_T1", 32'(b_en), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #4;
            chk("lat3_enable_wait", 32'(b_en), 32'd0);
            chk("lat3_rsp_early", 32'(b_rsp0_valid), 32'd0);
        end
        @(posedge clk); #4;
        chk("lat3_rsp_T5", 32'(b_rsp0_valid), 32'd1);
        chk("lat3_result", 32'(b_rsp_result), 32'h37);
        chk("lat3_status", 32'(b_rsp_status), 32'h00);
        chk("lat3_ready_T5", 32'(b_req0_ready), 32'd0);
        b_req0_valid = 1'b1; b_req0_a = 8'h12;
        @(posedge clk); #4;
        chk("lat3_ready_T6", 32'(b_req0_ready), 32'd1);
        chk("lat3_rsp_T6", 32'(b_rsp0_valid), 32'd0);
        @(posedge clk); #1 b_req0_valid = 1'b0;
        repeat (8) @(posedge clk);
        #4;

        // Reset asserted during WAIT: the command must vanish.
        a_req0_valid = 1'b1; a_req0_opcode = LDA_IMM; a_req0_a = 8'h55;
        #1;
        n = 0;
        while (!a_req0_ready && n < 30) begin
            @(posedge clk); #4; n++;
        end
        chk("midrst_ready_wait", 32'(n < 30), 32'd1);
        @(posedge clk); #1 a_req0_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #4;
            chk("midrst_no_rsp0", 32'(a_rsp0_valid), 32'd0);
            chk("midrst_no_rsp1", 32'(a_rsp1_valid), 32'd0);
        end
        a_req0_valid = 1'b1; a_req0_opcode = LDA_IMM; a_req0_a = 8'h11;
        a_req1_valid = DBG;  a_req1_opcode = LDA_IMM; a_req1_a = 8'h22;
        @(posedge clk); #1 rst = 1'b0; #3;
        chk("midrst_R_no_rsp", 32'(a_rsp0_valid), 32'd0);
        chk("midrst_result_cleared", 32'(a_rsp_result), 32'h00);
        @(posedge clk); #4;
        chk("midrst_R1_n_rst", 32'(a_n_rst), 32'd0);
        chk("midrst_R1_no_rsp", 32'(a_rsp0_valid), 32'd0);
        @(posedge clk); #4;
        chk("midrst_R2_n_rst", 32'(a_n_rst), 32'd1);

        // Both ports valid continuously: grants alternate starting with port 0.
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(a_req0_ready || a_req1_ready) && n < 30) begin
                @(posedge clk); #4; n++;
            end
            chk("arb_ready_wait", 32'(n < 30), 32'd1);
            g = a_req1_ready;
            chk("arb_grant", 32'(g), DBG ? 32'(i % 2) : 32'd0);
            repeat (2 + LAT_A) begin
                @(posedge clk); #4;
            end
            chk("arb_rsp0", 32'(a_rsp0_valid), 32'(!g));
            chk("arb_rsp1", 32'(a_rsp1_valid), 32'(g));
            chk("arb_result", 32'(a_rsp_result), g ? 32'h22 : 32'h11);
            chk("arb_status", 32'(a_rsp_status), 32'h00);
            if (i == 3) begin
                a_req0_valid = 1'b0;
                a_req1_valid = 1'b0;
            end
            @(posedge clk); #4;
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
